// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the 32x8 program/data RAM.
// Holds the program counter, issues single-byte reads to a RAM with registered
// read data, latches each fetched byte into INSTR and offers it to the execute
// stage over a valid/ready handshake. Supports execute-stage bus ownership
// (BUS_BUSY), jumps that flush the pipeline, and a halt opcode.
//
// Ports:
//   CLOCK        in   system clock, rising edge
//   RESET        in   asynchronous, active-high reset
//   Q_IN         in   RAM read data, valid one edge after the address is issued
//   BUS_BUSY     in   execute stage owns the RAM this cycle
//   ADDR         out  RAM address (always PC)
//   RD_EN        out  fetch owns the RAM this cycle
//   INSTR        out  instruction register
//   OPCODE       out  INSTR opcode field (top OPC_W bits)
//   OPERAND      out  INSTR operand field (low bits)
//   INSTR_VALID  out  INSTR holds an unconsumed instruction
//   INSTR_READY  in   execute accepts INSTR this cycle
//   JUMP         in   load PC from JUMP_ADDR and flush
//   JUMP_ADDR    in   jump target
//   PC           out  current program counter
//   HALTED       out  fetch stopped after a halt opcode was consumed
//
// state   | meaning
// ISSUE   | address on the RAM, waiting for the bus to be free
// CAPTURE | RAM data valid, latched into INSTR at this edge
// HOLD    | INSTR valid, waiting for the execute handshake
// HALT    | halt opcode consumed, only JUMP or RESET leaves

module fetch_unit #(
    parameter int                 ADDR_W   = 5,
    parameter int                 DATA_W   = 8,
    parameter int                 OPC_W    = 3,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [OPC_W-1:0]   HALT_OPC = 3'b111
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic [DATA_W-1:0]       Q_IN,
    input  logic                    BUS_BUSY,
    output logic [ADDR_W-1:0]       ADDR,
    output logic                    RD_EN,
    output logic [DATA_W-1:0]       INSTR,
    output logic [OPC_W-1:0]        OPCODE,
    output logic [ADDR_W-1:0]       OPERAND,
    output logic                    INSTR_VALID,
    input  logic                    INSTR_READY,
    input  logic                    JUMP,
    input  logic [ADDR_W-1:0]       JUMP_ADDR,
    output logic [ADDR_W-1:0]       PC,
    output logic                    HALTED
);

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                rd_en;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        rd_en   = 1'b0;

        case (state_q)
            ISSUE: begin
                rd_en = !BUS_BUSY;
                if (!BUS_BUSY) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // BUS_BUSY does not matter here: Q_IN was registered by the RAM
                // at the previous edge from our own address.
                instr_d = Q_IN;
                pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                state_d = HOLD;
            end
            HOLD: begin
                if (INSTR_READY) begin
                    state_d = (instr_q[DATA_W-1 -: OPC_W] == HALT_OPC) ? HALT : ISSUE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = ISSUE;
            end
        endcase

        // A jump overrides everything: a concurrent handshake is dropped and
        // data arriving in CAPTURE is thrown away (INSTR keeps its old value).
        if (JUMP) begin
            pc_d    = JUMP_ADDR;
            instr_d = instr_q;
            state_d = ISSUE;
        end
    end

    assign ADDR        = pc_q;
    assign PC          = pc_q;
    assign RD_EN       = rd_en;
    assign INSTR       = instr_q;
    assign OPCODE      = instr_q[DATA_W-1 -: OPC_W];
    assign OPERAND     = instr_q[DATA_W-OPC_W-1:0];
    assign INSTR_VALID = (state_q == HOLD);
    assign HALTED      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: behavioural RAM with registered read data, a
// scoreboard of expected accepted instructions, a table of jump vectors and
// hand-written sequences for backpressure, bus ownership, halt, jump during
// capture, PC wrap and asynchronous reset.

module tb_fetch_unit;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] Q_IN;
    logic       BUS_BUSY = 1'b0;
    logic [4:0] ADDR;
    logic       RD_EN;
    logic [7:0] INSTR;
    logic [2:0] OPCODE;
    logic [4:0] OPERAND;
    logic       INSTR_VALID;
    logic       INSTR_READY = 1'b0;
    logic       JUMP = 1'b0;
    logic [4:0] JUMP_ADDR = '0;
    logic [4:0] PC;
    logic       HALTED;

    fetch_unit dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .Q_IN        (Q_IN),
        .BUS_BUSY    (BUS_BUSY),
        .ADDR        (ADDR),
        .RD_EN       (RD_EN),
        .INSTR       (INSTR),
        .OPCODE      (OPCODE),
        .OPERAND     (OPERAND),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .JUMP        (JUMP),
        .JUMP_ADDR   (JUMP_ADDR),
        .PC          (PC),
        .HALTED      (HALTED)
    );

    always #5 CLOCK = ~CLOCK;

    // RAM model: registered read. When fetch does not own the bus the RAM
    // returns a pattern belonging to the execute stage's access.
    logic [7:0] mem [32];
    always @(posedge CLOCK) begin
        Q_IN <= RD_EN ? mem[ADDR] : 8'hA5;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    typedef struct packed {
        logic [7:0] instr;
        logic [4:0] pc;
    } exp_t;
    exp_t expq[$];

    // Scoreboard: a handshake happens at the next rising edge when VALID and
    // READY are high and no jump is pending.
    always @(negedge CLOCK) begin
        #2;
        if (!RESET && INSTR_VALID && INSTR_READY && !JUMP) begin
            if (expq.size() == 0) begin
                chk("sb_unexpected_instr", {24'h0, INSTR}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("sb_instr",   INSTR,   e.instr);
                chk("sb_opcode",  OPCODE,  e.instr[7:5]);
                chk("sb_operand", OPERAND, e.instr[4:0]);
                chk("sb_pc",      PC,      e.pc);
            end
        end
    end

    task automatic push(input logic [7:0] instr, input logic [4:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        expq.push_back(e);
    endtask

    // Counts negedges until INSTR_VALID; returns max+1 on timeout.
    task automatic wait_valid(input int max, output int cyc);
        cyc = max + 1;
        for (int i = 1; i <= max; i++) begin
            @(negedge CLOCK);
            if (INSTR_VALID) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic do_jump(input logic [4:0] addr);
        JUMP      = 1'b1;
        JUMP_ADDR = addr;
        @(negedge CLOCK);
        JUMP      = 1'b0;
    endtask

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] instr;
        logic [2:0] opc;
        logic [4:0] opd;
        logic [4:0] pc;
    } vec_t;
    vec_t tbl [6];

    initial begin
        int cyc;

        for (int i = 0; i < 32; i++) mem[i] = 8'h40 | 8'(i);
        mem[5'h00] = 8'h80;
        mem[5'h01] = 8'h3E;
        mem[5'h02] = 8'h80;
        mem[5'h03] = 8'h3F;
        mem[5'h0C] = 8'h1E;
        mem[5'h11] = 8'hFF;
        mem[5'h1F] = 8'h00;

        tbl[0] = '{addr: 5'h01, instr: 8'h3E, opc: 3'd1, opd: 5'd30, pc: 5'h02};
        tbl[1] = '{addr: 5'h0C, instr: 8'h1E, opc: 3'd0, opd: 5'd30, pc: 5'h0D};
        tbl[2] = '{addr: 5'h07, instr: 8'h47, opc: 3'd2, opd: 5'd7,  pc: 5'h08};
        tbl[3] = '{addr: 5'h1F, instr: 8'h00, opc: 3'd0, opd: 5'd0,  pc: 5'h00};
        tbl[4] = '{addr: 5'h1A, instr: 8'h5A, opc: 3'd2, opd: 5'd26, pc: 5'h1B};
        tbl[5] = '{addr: 5'h03, instr: 8'h3F, opc: 3'd1, opd: 5'd31, pc: 5'h04};

        // Reset state
        INSTR_READY = 1'b1;
        repeat (2) @(negedge CLOCK);
        chk("rst_instr",  INSTR,       8'h00);
        chk("rst_valid",  INSTR_VALID, 1'b0);
        chk("rst_halted", HALTED,      1'b0);
        chk("rst_pc",     PC,          5'h00);

        // Free-running preload, one instruction every three cycles
        push(8'h80, 5'h01);
        push(8'h3E, 5'h02);
        push(8'h80, 5'h03);
        push(8'h3F, 5'h04);
        RESET = 1'b0;
        wait_valid(6, cyc);
        chk("first_latency", cyc, 2);
        chk("first_instr", INSTR, 8'h80);
        wait_valid(6, cyc);
        chk("run_period", cyc, 3);
        chk("run_opcode_3e",  OPCODE,  3'b001);
        chk("run_operand_3e", OPERAND, 5'd30);
        wait_valid(6, cyc);
        chk("run_period", cyc, 3);
        wait_valid(6, cyc);
        chk("run_period", cyc, 3);
        chk("run_instr_3f", INSTR, 8'h3F);
        @(negedge CLOCK);

        // Table of jump targets
        foreach (tbl[k]) begin
            push(tbl[k].instr, tbl[k].pc);
            do_jump(tbl[k].addr);
            chk("tbl_valid_after_jump", INSTR_VALID, 1'b0);
            wait_valid(6, cyc);
            chk("tbl_latency", cyc, 2);
            chk("tbl_instr",   INSTR,   tbl[k].instr);
            chk("tbl_opcode",  OPCODE,  tbl[k].opc);
            chk("tbl_operand", OPERAND, tbl[k].opd);
            chk("tbl_pc",      PC,      tbl[k].pc);
            @(negedge CLOCK);
        end

        // Backpressure on 0x1E
        INSTR_READY = 1'b0;
        push(8'h1E, 5'h0D);
        do_jump(5'h0C);
        wait_valid(6, cyc);
        chk("bp_latency", cyc, 2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", INSTR_VALID, 1'b1);
            chk("bp_instr", INSTR, 8'h1E);
            chk("bp_pc",    PC,    5'h0D);
            chk("bp_rd_en", RD_EN, 1'b0);
            @(negedge CLOCK);
        end
        INSTR_READY = 1'b1;
        push(8'h4D, 5'h0E);
        @(negedge CLOCK);
        chk("bp_next_rd_en", RD_EN, 1'b1);
        chk("bp_next_addr",  ADDR,  5'h0D);
        wait_valid(6, cyc);
        chk("bp_next_latency", cyc, 2);
        @(negedge CLOCK);

        // Execute stage owns the bus for four cycles during ISSUE
        for (int i = 0; i < 4; i++) begin
            BUS_BUSY = 1'b1;
            #1;
            chk("busy_rd_en", RD_EN, 1'b0);
            chk("busy_pc",    PC,    5'h0E);
            @(negedge CLOCK);
        end
        BUS_BUSY = 1'b0;
        push(8'h4E, 5'h0F);
        wait_valid(6, cyc);
        chk("busy_latency", cyc, 2);
        chk("busy_instr", INSTR, 8'h4E);

        // BUS_BUSY raised while in CAPTURE is ignored
        push(8'h4F, 5'h10);
        @(negedge CLOCK);
        @(negedge CLOCK);
        BUS_BUSY = 1'b1;
        @(negedge CLOCK);
        BUS_BUSY = 1'b0;
        chk("busy_cap_valid", INSTR_VALID, 1'b1);
        chk("busy_cap_instr", INSTR, 8'h4F);

        // Halt
        push(8'h50, 5'h11);
        push(8'hFF, 5'h12);
        wait_valid(6, cyc);
        chk("pre_halt_instr", INSTR, 8'h50);
        wait_valid(6, cyc);
        chk("halt_instr",  INSTR,  8'hFF);
        chk("halt_opcode", OPCODE, 3'b111);
        @(negedge CLOCK);
        for (int i = 0; i < 4; i++) begin
            chk("halt_halted", HALTED,      1'b1);
            chk("halt_valid",  INSTR_VALID, 1'b0);
            chk("halt_pc",     PC,          5'h12);
            chk("halt_rd_en",  RD_EN,       1'b0);
            @(negedge CLOCK);
        end
        push(8'h80, 5'h01);
        do_jump(5'h00);
        chk("unhalt_halted", HALTED, 1'b0);
        wait_valid(6, cyc);
        chk("unhalt_latency", cyc, 2);
        chk("unhalt_instr", INSTR, 8'h80);

        // Jump during CAPTURE discards the captured byte
        @(negedge CLOCK);
        @(negedge CLOCK);
        push(8'h1E, 5'h0D);
        do_jump(5'h0C);
        chk("jcap_valid", INSTR_VALID, 1'b0);
        chk("jcap_pc",    PC,    5'h0C);
        chk("jcap_instr", INSTR, 8'h80);
        wait_valid(6, cyc);
        chk("jcap_latency", cyc, 2);
        chk("jcap_next_instr", INSTR, 8'h1E);
        chk("jcap_next_pc",    PC,    5'h0D);

        // Asynchronous reset in the middle of CAPTURE
        @(negedge CLOCK);
        @(negedge CLOCK);
        #1;
        RESET = 1'b1;
        #1;
        chk("arst_instr",  INSTR,       8'h00);
        chk("arst_valid",  INSTR_VALID, 1'b0);
        chk("arst_pc",     PC,          5'h00);
        chk("arst_halted", HALTED,      1'b0);
        #1;
        RESET = 1'b0;
        push(8'h80, 5'h01);
        wait_valid(6, cyc);
        chk("arst_latency", cyc, 2);
        chk("arst_restart_instr", INSTR, 8'h80);
        @(negedge CLOCK);

        chk("sb_drain", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
